// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - opcodes, exception bit positions, size encodings and MEM-stage types
package mem_access_pkg;

  localparam logic [7:0] ALUOP_LB  = 8'hE0;
  localparam logic [7:0] ALUOP_LBU = 8'hE4;
  localparam logic [7:0] ALUOP_LH  = 8'hE1;
  localparam logic [7:0] ALUOP_LHU = 8'hE5;
  localparam logic [7:0] ALUOP_LW  = 8'hE3;
  localparam logic [7:0] ALUOP_SB  = 8'hE8;
  localparam logic [7:0] ALUOP_SH  = 8'hE9;
  localparam logic [7:0] ALUOP_SW  = 8'hEB;

  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Instruction fields captured when a request is issued.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        wr;
    logic        cached;
  } req_t;

  function automatic logic [1:0] aluop_size(input logic [7:0] op);
    case (op)
      ALUOP_LB, ALUOP_LBU, ALUOP_SB: aluop_size = SIZE_BYTE;
      ALUOP_LH, ALUOP_LHU, ALUOP_SH: aluop_size = SIZE_HALF;
      default:                       aluop_size = SIZE_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = |addr_lo;
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - load extract/extend and store replicate/strobe, purely combinational
module mem_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [1:0]  size
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    size  = aluop_size(aluop);
    rbyte = rdata[{addr_lo, 3'b000} +: 8];
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (aluop)
      ALUOP_LB:  load_data = {{24{rbyte[7]}}, rbyte};
      ALUOP_LBU: load_data = {24'd0, rbyte};
      ALUOP_LH:  load_data = {{16{rhalf[15]}}, rhalf};
      ALUOP_LHU: load_data = {16'd0, rhalf};
      default:   load_data = rdata;
    endcase

    case (size)
      SIZE_BYTE: begin
        wdata = {4{sdata[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        wdata = {2{sdata[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = sdata;
        wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: bus request FSM, kill-on-flush draining, held result and stall request
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_hold,
  input  logic [4:0]        i_wd,
  input  logic              i_wreg,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [7:0]        i_aluop,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_sdata,
  input  logic              i_l_op,
  input  logic              i_s_op,
  input  logic              i_cached,
  input  logic [31:0]       i_excepttype,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  output logic              data_cached,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [4:0]        o_wd,
  output logic              o_wreg,
  output logic [DATA_W-1:0] o_wdata,
  output logic [31:0]       o_excepttype,
  output logic [ADDR_W-1:0] o_badvaddr,
  output logic              stallreq
);

  state_e      state_q, state_d;
  logic        killed_q, killed_d;
  logic [31:0] hold_q, hold_d;
  req_t        req_q, req_d;

  logic        is_mem, adex, adel, ades, start;
  logic        in_idle, in_req, in_wait, in_done, killed, req;
  logic [7:0]  sel_aluop;
  logic [31:0] sel_addr, sel_sdata, result_data;
  logic        sel_wr, sel_cached;
  logic [31:0] load_data, al_wdata;
  logic [3:0]  al_wstrb;
  logic [1:0]  al_size;

  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign in_wait = (state_q == ST_WAIT);
  assign in_done = (state_q == ST_DONE);

  assign is_mem = i_l_op | i_s_op;
  assign adex   = is_mem & misaligned(aluop_size(i_aluop), i_addr[1:0]);
  assign adel   = i_l_op & adex;
  assign ades   = i_s_op & adex;
  // Only IDLE may issue; in DONE the held EX/MEM still carries the completed access.
  assign start  = in_idle & is_mem & ~adex & (i_excepttype == 32'd0) & ~flush;

  assign killed = killed_q | (flush & (in_req | in_wait));

  // Once issued, the bus sees the frozen fields even if the pipeline is flushed.
  assign sel_aluop  = in_idle ? i_aluop  : req_q.aluop;
  assign sel_addr   = in_idle ? i_addr   : req_q.addr;
  assign sel_sdata  = in_idle ? i_sdata  : req_q.sdata;
  assign sel_wr     = in_idle ? i_s_op   : req_q.wr;
  assign sel_cached = in_idle ? i_cached : req_q.cached;

  mem_align u_align (
    .aluop     (sel_aluop),
    .addr_lo   (sel_addr[1:0]),
    .sdata     (sel_sdata),
    .rdata     (data_rdata),
    .load_data (load_data),
    .wdata     (al_wdata),
    .wstrb     (al_wstrb),
    .size      (al_size)
  );

  assign result_data = req_q.wr ? req_q.wdata : load_data;

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    hold_d   = hold_q;
    req_d    = req_q;
    req      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req = start;
        if (start) begin
          req_d = '{aluop: i_aluop, addr: i_addr, sdata: i_sdata, wdata: i_wdata,
                    wd: i_wd, wreg: i_wreg, wr: i_s_op, cached: i_cached};
          state_d = data_addr_ok ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        req      = 1'b1;
        killed_d = killed_q | flush;
        if (data_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        killed_d = killed_q | flush;
        if (data_data_ok) begin
          killed_d = 1'b0;
          if (stall_hold && !killed) begin
            state_d = ST_DONE;
            hold_d  = result_data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (flush || !stall_hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      killed_q <= 1'b0;
      hold_q   <= 32'd0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      hold_q   <= hold_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    data_req    = rst & req;
    data_wr     = data_req & sel_wr;
    data_size   = data_req ? al_size : 2'd0;
    data_addr   = data_req ? sel_addr : '0;
    data_wdata  = (data_req & sel_wr) ? al_wdata : '0;
    data_wstrb  = (data_req & sel_wr) ? al_wstrb : 4'd0;
    data_cached = data_req & sel_cached;
    stallreq    = rst & (start | in_req | (in_wait & ~data_data_ok)
                         | (killed_q & ~(in_wait & data_data_ok)));

    o_wd         = 5'd0;
    o_wreg       = 1'b0;
    o_wdata      = '0;
    o_excepttype = 32'd0;
    o_badvaddr   = '0;
    if (rst && !killed && !(flush && (in_idle || in_done))) begin
      case (state_q)
        ST_IDLE: begin
          o_wd         = i_wd;
          o_wreg       = i_l_op ? 1'b0 : (i_wreg & ~adex);
          o_wdata      = i_wdata;
          o_excepttype = i_excepttype | ({31'd0, adel} << EXC_ADEL) | ({31'd0, ades} << EXC_ADES);
          o_badvaddr   = adex ? i_addr : '0;
        end
        ST_REQ: begin
          o_wd = req_q.wd;
        end
        ST_WAIT: begin
          o_wd = req_q.wd;
          if (data_data_ok) begin
            o_wreg  = req_q.wreg;
            o_wdata = result_data;
          end
        end
        ST_DONE: begin
          o_wd    = req_q.wd;
          o_wreg  = req_q.wreg;
          o_wdata = hold_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - vector table plus directed multi-cycle sequences for mem_access
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, stall_hold;
  logic [4:0]  i_wd;
  logic        i_wreg;
  logic [31:0] i_wdata;
  logic [7:0]  i_aluop;
  logic [31:0] i_addr, i_sdata;
  logic        i_l_op, i_s_op, i_cached;
  logic [31:0] i_excepttype;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_cached;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [4:0]  o_wd;
  logic        o_wreg;
  logic [31:0] o_wdata, o_excepttype, o_badvaddr;
  logic        stallreq;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_hold(stall_hold),
    .i_wd(i_wd), .i_wreg(i_wreg), .i_wdata(i_wdata), .i_aluop(i_aluop),
    .i_addr(i_addr), .i_sdata(i_sdata), .i_l_op(i_l_op), .i_s_op(i_s_op),
    .i_cached(i_cached), .i_excepttype(i_excepttype),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_cached(data_cached), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .o_wd(o_wd), .o_wreg(o_wreg), .o_wdata(o_wdata),
    .o_excepttype(o_excepttype), .o_badvaddr(o_badvaddr), .stallreq(stallreq)
  );

  typedef struct {
    logic [7:0]  op;
    logic        l, s;
    logic [31:0] addr, sdata, rdata, exc;
    logic        wreg;
    logic        e_req;
    logic [1:0]  e_size;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_exc, e_bad, e_res;
    logic        e_wreg;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush = 0; stall_hold = 0; i_wd = 5'd7; i_wreg = 0; i_wdata = 32'h0000_5555;
    i_aluop = 8'h00; i_addr = 0; i_sdata = 0; i_l_op = 0; i_s_op = 0; i_cached = 1;
    i_excepttype = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic drive_op(input logic [7:0] op, input logic l, input logic s,
                          input logic [31:0] addr, input logic [31:0] sdata);
    i_aluop = op; i_l_op = l; i_s_op = s; i_addr = addr; i_sdata = sdata; i_wreg = l;
  endtask

  initial begin
    //          op        l  s  addr          sdata         rdata         exc       wreg req size wdata        strb     e_exc     e_bad         e_res         e_wreg
    vecs[0]  = '{ALUOP_LW,  1, 0, 32'h1000, 32'h0,        32'hDEADBEEF, 32'h0,   1, 1, 2'd2, 32'h0,        4'h0,    32'h0,    32'h0,        32'hDEADBEEF, 1};
    vecs[1]  = '{ALUOP_LB,  1, 0, 32'h1003, 32'h0,        32'h80FFFFFF, 32'h0,   1, 1, 2'd0, 32'h0,        4'h0,    32'h0,    32'h0,        32'hFFFFFF80, 1};
    vecs[2]  = '{ALUOP_LBU, 1, 0, 32'h1003, 32'h0,        32'h80FFFFFF, 32'h0,   1, 1, 2'd0, 32'h0,        4'h0,    32'h0,    32'h0,        32'h00000080, 1};
    vecs[3]  = '{ALUOP_LHU, 1, 0, 32'h1002, 32'h0,        32'h80FFFFFF, 32'h0,   1, 1, 2'd1, 32'h0,        4'h0,    32'h0,    32'h0,        32'h000080FF, 1};
    vecs[4]  = '{ALUOP_LH,  1, 0, 32'h1002, 32'h0,        32'h80FFFFFF, 32'h0,   1, 1, 2'd1, 32'h0,        4'h0,    32'h0,    32'h0,        32'hFFFF80FF, 1};
    vecs[5]  = '{ALUOP_LB,  1, 0, 32'h1000, 32'h0,        32'h80FFFF7F, 32'h0,   1, 1, 2'd0, 32'h0,        4'h0,    32'h0,    32'h0,        32'h0000007F, 1};
    vecs[6]  = '{ALUOP_LH,  1, 0, 32'h1000, 32'h0,        32'h12348001, 32'h0,   1, 1, 2'd1, 32'h0,        4'h0,    32'h0,    32'h0,        32'hFFFF8001, 1};
    vecs[7]  = '{ALUOP_SB,  0, 1, 32'h2001, 32'h000000A5, 32'h0,        32'h0,   0, 1, 2'd0, 32'hA5A5A5A5, 4'b0010, 32'h0,    32'h0,        32'h00005555, 0};
    vecs[8]  = '{ALUOP_SW,  0, 1, 32'h2004, 32'hCAFEF00D, 32'h0,        32'h0,   0, 1, 2'd2, 32'hCAFEF00D, 4'b1111, 32'h0,    32'h0,        32'h00005555, 0};
    vecs[9]  = '{ALUOP_SH,  0, 1, 32'h2000, 32'h1234ABCD, 32'h0,        32'h0,   0, 1, 2'd1, 32'hABCDABCD, 4'b0011, 32'h0,    32'h0,        32'h00005555, 0};
    vecs[10] = '{ALUOP_LW,  1, 0, 32'h1001, 32'h0,        32'h0,        32'h0,   1, 0, 2'd0, 32'h0,        4'h0,    32'h10,   32'h1001,     32'h00005555, 0};
    vecs[11] = '{ALUOP_SW,  0, 1, 32'h1002, 32'h0,        32'h0,        32'h0,   1, 0, 2'd0, 32'h0,        4'h0,    32'h20,   32'h1002,     32'h00005555, 0};
    vecs[12] = '{ALUOP_LH,  1, 0, 32'h1001, 32'h0,        32'h0,        32'h0,   1, 0, 2'd0, 32'h0,        4'h0,    32'h10,   32'h1001,     32'h00005555, 0};
    vecs[13] = '{8'h21,     0, 0, 32'h1003, 32'h0,        32'h0,        32'h0,   1, 0, 2'd0, 32'h0,        4'h0,    32'h0,    32'h0,        32'h00005555, 1};
    vecs[14] = '{ALUOP_LW,  1, 0, 32'h1000, 32'h0,        32'h0,        32'h100, 1, 0, 2'd0, 32'h0,        4'h0,    32'h100,  32'h0,        32'h00005555, 0};
    vecs[15] = '{ALUOP_SH,  0, 1, 32'h2003, 32'h0,        32'h0,        32'h0,   0, 0, 2'd0, 32'h0,        4'h0,    32'h20,   32'h2003,     32'h00005555, 0};

    // Reset: a valid load is presented but every output must stay 0.
    idle_in();
    rst = 0;
    drive_op(ALUOP_LW, 1, 0, 32'h1000, 32'h0);
    i_excepttype = 32'h10; i_wreg = 1; data_addr_ok = 1;
    tick(); #4;
    chk("rst data_req", 32'(data_req), 32'd0);
    chk("rst stallreq", 32'(stallreq), 32'd0);
    chk("rst o_wreg", 32'(o_wreg), 32'd0);
    chk("rst o_wdata", o_wdata, 32'd0);
    chk("rst o_excepttype", o_excepttype, 32'd0);
    tick(); idle_in(); rst = 1;

    for (int k = 0; k < NV; k++) begin
      tick(); idle_in();
      drive_op(vecs[k].op, vecs[k].l, vecs[k].s, vecs[k].addr, vecs[k].sdata);
      i_wreg = vecs[k].wreg; i_excepttype = vecs[k].exc; data_addr_ok = vecs[k].e_req;
      #4;
      chk($sformatf("v%0d data_req", k), 32'(data_req), 32'(vecs[k].e_req));
      chk($sformatf("v%0d stallreq", k), 32'(stallreq), 32'(vecs[k].e_req));
      chk($sformatf("v%0d o_excepttype", k), o_excepttype, vecs[k].e_exc);
      chk($sformatf("v%0d o_badvaddr", k), o_badvaddr, vecs[k].e_bad);
      if (vecs[k].e_req) begin
        chk($sformatf("v%0d data_size", k), 32'(data_size), 32'(vecs[k].e_size));
        chk($sformatf("v%0d data_wr", k), 32'(data_wr), 32'(vecs[k].s));
        chk($sformatf("v%0d issue o_wreg", k), 32'(o_wreg), 32'd0);
        if (vecs[k].s) begin
          chk($sformatf("v%0d data_wdata", k), data_wdata, vecs[k].e_wdata);
          chk($sformatf("v%0d data_wstrb", k), 32'(data_wstrb), 32'(vecs[k].e_strb));
        end
        tick();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = vecs[k].rdata;
        #4;
        chk($sformatf("v%0d done stallreq", k), 32'(stallreq), 32'd0);
        chk($sformatf("v%0d o_wdata", k), o_wdata, vecs[k].e_res);
        chk($sformatf("v%0d o_wreg", k), 32'(o_wreg), 32'(vecs[k].e_wreg));
        chk($sformatf("v%0d done o_excepttype", k), o_excepttype, 32'd0);
      end else begin
        chk($sformatf("v%0d o_wdata", k), o_wdata, vecs[k].e_res);
        chk($sformatf("v%0d o_wreg", k), 32'(o_wreg), 32'(vecs[k].e_wreg));
      end
    end

    // LW with data_ok two cycles after acceptance: stallreq 1,1,0.
    tick(); idle_in(); drive_op(ALUOP_LW, 1, 0, 32'h1000, 32'h0); data_addr_ok = 1;
    #4; chk("lw c0 stallreq", 32'(stallreq), 32'd1);
    tick(); data_addr_ok = 0;
    #4; chk("lw c1 stallreq", 32'(stallreq), 32'd1);
    chk("lw c1 data_req", 32'(data_req), 32'd0);
    tick(); data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    #4; chk("lw c2 stallreq", 32'(stallreq), 32'd0);
    chk("lw c2 o_wdata", o_wdata, 32'hDEADBEEF);
    chk("lw c2 o_wreg", 32'(o_wreg), 32'd1);

    // SH held in REQ for three cycles; fields frozen even if inputs move.
    tick(); idle_in(); drive_op(ALUOP_SH, 0, 1, 32'h2002, 32'h1234ABCD);
    for (int c = 0; c < 3; c++) begin
      data_addr_ok = (c == 2);
      #4;
      chk($sformatf("sh c%0d data_req", c), 32'(data_req), 32'd1);
      chk($sformatf("sh c%0d data_addr", c), data_addr, 32'h2002);
      chk($sformatf("sh c%0d data_wdata", c), data_wdata, 32'hABCDABCD);
      chk($sformatf("sh c%0d data_wstrb", c), 32'(data_wstrb), 32'b1100);
      chk($sformatf("sh c%0d data_size", c), 32'(data_size), 32'd1);
      tick(); i_addr = 32'h3000; i_sdata = 32'h0;
    end
    data_addr_ok = 0; data_data_ok = 1;
    #4; chk("sh done data_req", 32'(data_req), 32'd0);
    chk("sh done stallreq", 32'(stallreq), 32'd0);

    // Flush while waiting: drains silently, then IDLE.
    tick(); idle_in(); drive_op(ALUOP_LW, 1, 0, 32'h1000, 32'h0); data_addr_ok = 1;
    tick(); idle_in(); flush = 1; i_wreg = 1; i_excepttype = 32'h400;
    #4; chk("fl c1 o_wreg", 32'(o_wreg), 32'd0);
    chk("fl c1 o_excepttype", o_excepttype, 32'd0);
    chk("fl c1 stallreq", 32'(stallreq), 32'd1);
    tick(); idle_in(); i_wreg = 1;
    #4; chk("fl c2 o_wreg", 32'(o_wreg), 32'd0);
    chk("fl c2 stallreq", 32'(stallreq), 32'd1);
    tick(); data_data_ok = 1; data_rdata = 32'h12345678;
    #4; chk("fl c3 o_wreg", 32'(o_wreg), 32'd0);
    tick(); idle_in(); i_aluop = 8'h21; i_wreg = 1; i_wdata = 32'h99;
    #4; chk("fl idle o_wreg", 32'(o_wreg), 32'd1);
    chk("fl idle o_wdata", o_wdata, 32'h99);
    chk("fl idle stallreq", 32'(stallreq), 32'd0);

    // Flush in IDLE zeroes the outputs and blocks a request.
    tick(); idle_in(); drive_op(ALUOP_LW, 1, 0, 32'h1000, 32'h0); flush = 1; data_addr_ok = 1;
    #4; chk("fi data_req", 32'(data_req), 32'd0);
    chk("fi o_wdata", o_wdata, 32'd0);
    chk("fi stallreq", 32'(stallreq), 32'd0);

    // data_ok under stall_hold: DONE keeps the result, no re-issue, IDLE on release.
    tick(); idle_in(); drive_op(ALUOP_LW, 1, 0, 32'h1004, 32'h0); data_addr_ok = 1;
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h11223344; stall_hold = 1;
    #4; chk("dn c1 o_wdata", o_wdata, 32'h11223344);
    chk("dn c1 stallreq", 32'(stallreq), 32'd0);
    for (int c = 2; c < 5; c++) begin
      tick(); data_rdata = 32'hBAD0BAD0; data_addr_ok = 1; stall_hold = (c < 4);
      #4;
      chk($sformatf("dn c%0d data_req", c), 32'(data_req), 32'd0);
      chk($sformatf("dn c%0d o_wdata", c), o_wdata, 32'h11223344);
      chk($sformatf("dn c%0d o_wreg", c), 32'(o_wreg), 32'd1);
    end
    tick(); idle_in(); i_aluop = 8'h21; i_wreg = 1; i_wdata = 32'h77;
    #4; chk("dn rel data_req", 32'(data_req), 32'd0);
    chk("dn rel o_wdata", o_wdata, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
